// File: rtl/sobel_frame_ctrl_if.sv
// sobel_frame_ctrl_if: pixel-memory read port, filter stream and tagged-result bus of the frame sequencer
interface sobel_frame_ctrl_if #(
    parameter int WIDTH      = 64,
    parameter int HEIGHT     = 64,
    parameter int DATA_WIDTH = 8,
    parameter int GRAD_WIDTH = 11,
    parameter int ADDR_WIDTH = $clog2(WIDTH*HEIGHT)
);
    logic                      mem_rd_en;
    logic [ADDR_WIDTH-1:0]     mem_addr;
    logic [DATA_WIDTH-1:0]     mem_rdata;
    logic                      flt_recv_data;
    logic [DATA_WIDTH-1:0]     flt_pixel;
    logic [GRAD_WIDTH-1:0]     flt_gradient;
    logic                      flt_gradient_valid;
    logic                      out_valid;
    logic [GRAD_WIDTH-1:0]     out_data;
    logic [$clog2(WIDTH)-1:0]  out_col;
    logic [$clog2(HEIGHT)-1:0] out_row;

    modport master (
        output mem_rd_en, mem_addr, flt_recv_data, flt_pixel, out_valid, out_data, out_col, out_row,
        input  mem_rdata, flt_gradient, flt_gradient_valid
    );
    modport slave (
        input  mem_rd_en, mem_addr, flt_recv_data, flt_pixel, out_valid, out_data, out_col, out_row,
        output mem_rdata, flt_gradient, flt_gradient_valid
    );
endinterface

// File: rtl/sobel_frame_ctrl.sv
// sobel_frame_ctrl: streams one frame into sobel_filter and tags/counts its results; THRESHOLD_EN adds edge flagging
module sobel_frame_ctrl #(
    parameter int WIDTH      = 64,
    parameter int HEIGHT     = 64,
    parameter int DATA_WIDTH = 8,
    parameter int GRAD_WIDTH = 11,
    parameter int DRAIN_MAX  = 256,
    parameter int ADDR_WIDTH = $clog2(WIDTH*HEIGHT)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start,
    input  logic                           pause,
    sobel_frame_ctrl_if.master             bus,
`ifdef THRESHOLD_EN
    input  logic [GRAD_WIDTH-1:0]          threshold,
    output logic                           out_edge,
    output logic [$clog2(WIDTH*HEIGHT):0]  edge_cnt,
`endif
    output logic [$clog2(WIDTH*HEIGHT):0]  grad_cnt,
    output logic                           busy,
    output logic                           done,
    output logic                           err_timeout
);
    localparam int CW = $clog2(WIDTH*HEIGHT) + 1;
    localparam int XW = $clog2(WIDTH);
    localparam int YW = $clog2(HEIGHT);
    localparam int IW = $clog2(DRAIN_MAX + 1);
    localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(WIDTH*HEIGHT - 1);
    localparam logic [CW-1:0]         NRES = CW'((WIDTH-2)*(HEIGHT-2));
    localparam logic [XW-1:0]         XMAX = XW'(WIDTH - 2);
    localparam logic [IW-1:0]         DMAX = IW'(DRAIN_MAX);

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  rd1_q, rd1_d, recv_q, recv_d;
    logic [DATA_WIDTH-1:0] pix_q, pix_d;
    logic                  ov_q, ov_d;
    logic [GRAD_WIDTH-1:0] od_q, od_d;
    logic [XW-1:0]         col_q, col_d, ocol_q, ocol_d;
    logic [YW-1:0]         row_q, row_d, orow_q, orow_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [IW-1:0]         idle_q, idle_d;
    logic                  done_q, done_d, err_q, err_d;
    logic                  rd_en, go, acc, wrap, fin;

    assign rd_en = state_q == FETCH && !pause;
    assign go    = state_q == IDLE && start;
    // results beyond the expected count are dropped so grad_cnt never overshoots
    assign acc   = state_q != IDLE && bus.flt_gradient_valid && cnt_q != NRES;
    assign wrap  = col_q == XMAX;

    always_comb begin
        rd1_d   = rd_en;
        recv_d  = rd1_q;
        pix_d   = rd1_q ? bus.mem_rdata : pix_q;
        addr_d  = go ? '0 : (rd_en && addr_q != LAST) ? addr_q + ADDR_WIDTH'(1) : addr_q;
        cnt_d   = go ? '0 : cnt_q + CW'(acc);
        col_d   = go ? XW'(1) : acc ? (wrap ? XW'(1) : col_q + XW'(1)) : col_q;
        row_d   = go ? YW'(1) : row_q + YW'(acc && wrap);
        ov_d    = acc;
        od_d    = acc ? bus.flt_gradient : od_q;
        ocol_d  = acc ? col_q : ocol_q;
        orow_d  = acc ? row_q : orow_q;
        idle_d  = (state_q == DRAIN && !bus.flt_gradient_valid) ? idle_q + IW'(1) : '0;
        // completion looks at the post-update count so the last result and done can share a cycle
        fin     = state_q == DRAIN && (cnt_d == NRES || idle_d == DMAX);
        done_d  = fin;
        err_d   = go ? 1'b0 : err_q || (fin && cnt_d != NRES);
        state_d = go ? FETCH : (rd_en && addr_q == LAST) ? DRAIN : fin ? IDLE : state_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            rd1_q   <= 1'b0;
            recv_q  <= 1'b0;
            pix_q   <= '0;
            ov_q    <= 1'b0;
            od_q    <= '0;
            col_q   <= '0;
            row_q   <= '0;
            ocol_q  <= '0;
            orow_q  <= '0;
            cnt_q   <= '0;
            idle_q  <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            rd1_q   <= rd1_d;
            recv_q  <= recv_d;
            pix_q   <= pix_d;
            ov_q    <= ov_d;
            od_q    <= od_d;
            col_q   <= col_d;
            row_q   <= row_d;
            ocol_q  <= ocol_d;
            orow_q  <= orow_d;
            cnt_q   <= cnt_d;
            idle_q  <= idle_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

`ifdef THRESHOLD_EN
    logic [GRAD_WIDTH-1:0] thr_q, thr_d;
    logic                  edge_q, edge_d, hit;
    logic [CW-1:0]         ecnt_q, ecnt_d;

    assign hit = bus.flt_gradient >= thr_q;

    always_comb begin
        thr_d  = go ? threshold : thr_q;
        edge_d = acc ? hit : edge_q;
        ecnt_d = go ? '0 : ecnt_q + CW'(acc && hit);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            thr_q  <= '0;
            edge_q <= 1'b0;
            ecnt_q <= '0;
        end else begin
            thr_q  <= thr_d;
            edge_q <= edge_d;
            ecnt_q <= ecnt_d;
        end
    end

    assign out_edge = edge_q;
    assign edge_cnt = ecnt_q;
`endif

    assign bus.mem_rd_en     = rd_en;
    assign bus.mem_addr      = addr_q;
    assign bus.flt_recv_data = recv_q;
    assign bus.flt_pixel     = pix_q;
    assign bus.out_valid     = ov_q;
    assign bus.out_data      = od_q;
    assign bus.out_col       = ocol_q;
    assign bus.out_row       = orow_q;
    assign grad_cnt          = cnt_q;
    assign busy              = state_q != IDLE;
    assign done              = done_q;
    assign err_timeout       = err_q;
endmodule

// File: tb/tb_sobel_frame_ctrl.sv
// tb_sobel_frame_ctrl: random frames against a counter-level reference model, plus pinned literal expectations
`timescale 1ns/1ps
module tb_sobel_frame_ctrl;
    localparam int W  = 8;
    localparam int H  = 5;
    localparam int DW = 8;
    localparam int GW = 11;
    localparam int DM = 16;
    localparam int AW = $clog2(W*H);
    localparam int P  = W*H;
    localparam int N  = (W-2)*(H-2);
    localparam int CW = $clog2(P) + 1;

    logic clk = 0, rst = 0, start = 0, pause = 0;
    logic [CW-1:0] grad_cnt;
    logic busy, done, err_timeout;
`ifdef THRESHOLD_EN
    logic [GW-1:0] threshold = '0;
    logic out_edge;
    logic [CW-1:0] edge_cnt;
`endif

    sobel_frame_ctrl_if #(.WIDTH(W), .HEIGHT(H), .DATA_WIDTH(DW), .GRAD_WIDTH(GW), .ADDR_WIDTH(AW)) bus();

    sobel_frame_ctrl #(.WIDTH(W), .HEIGHT(H), .DATA_WIDTH(DW), .GRAD_WIDTH(GW), .DRAIN_MAX(DM), .ADDR_WIDTH(AW)) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .pause(pause),
        .bus(bus.master),
`ifdef THRESHOLD_EN
        .threshold(threshold),
        .out_edge(out_edge),
        .edge_cnt(edge_cnt),
`endif
        .grad_cnt(grad_cnt),
        .busy(busy),
        .done(done),
        .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    logic [DW-1:0] mem_img [P];
    always @(posedge clk) if (bus.mem_rd_en) bus.mem_rdata <= mem_img[bus.mem_addr];

    int n_tests = 0, n_fail = 0;
    function automatic void chk(string name, longint act, longint exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endfunction

    // reference model: frame progress expressed as counts of issued reads and accepted results
    bit m_act, m_rec, m_ov, m_done, m_err, rd1;
    int m_iss, m_acc, m_idle, addr1, m_col, m_row;
    logic [GW-1:0] m_od;
    logic [DW-1:0] m_pix;
    int cyc = 0, strobes = 0, done_total = 0, last_rd_cyc = 0, done_cyc = 0;
    int coords[$];
    logic [GW-1:0] m_thr;
    bit m_edge;
    int m_ecnt;
    bit edges[$];

    function automatic int exp_addr();
        return m_iss >= P ? P-1 : m_iss;
    endfunction
    function automatic bit exp_rd();
        return m_act && m_iss < P && !pause;
    endfunction

    function automatic void model_reset();
        m_act = 0; m_rec = 0; m_ov = 0; m_done = 0; m_err = 0; rd1 = 0;
        m_iss = 0; m_acc = 0; m_idle = 0; addr1 = 0; m_col = 0; m_row = 0;
        m_od = '0; m_pix = '0; m_thr = '0; m_edge = 0; m_ecnt = 0; strobes = 0;
    endfunction

    function automatic void model_step();
        bit rd, drain, acc, was;
        int a;
        rd = exp_rd();
        a = exp_addr();
        was = m_act;
        drain = m_act && m_iss == P;
        acc = m_act && bus.flt_gradient_valid && m_acc < N;
        m_ov = acc;
        if (acc) begin
            m_od = bus.flt_gradient;
            m_col = 1 + m_acc % (W-2);
            m_row = 1 + m_acc / (W-2);
            m_acc++;
            m_edge = bus.flt_gradient >= m_thr;
            m_ecnt += int'(m_edge);
        end
        m_rec = rd1;
        if (rd1) m_pix = mem_img[addr1];
        rd1 = rd;
        addr1 = a;
        m_done = 0;
        if (drain) begin
            m_idle = bus.flt_gradient_valid ? 0 : m_idle + 1;
            if (m_acc == N || m_idle == DM) begin
                if (m_acc != N) m_err = 1;
                m_act = 0;
                m_done = 1;
            end
        end else m_idle = 0;
        if (rd) begin
            m_iss++;
            last_rd_cyc = cyc;
        end
        if (!was && start) begin
            m_act = 1; m_iss = 0; m_acc = 0; m_err = 0; m_ecnt = 0; strobes = 0;
            coords.delete();
            edges.delete();
`ifdef THRESHOLD_EN
            m_thr = threshold;
`endif
        end
    endfunction

    initial begin
        model_reset();
        forever begin
            @(posedge clk);
            if (!rst) model_reset();
            else model_step();
            cyc++;
            @(negedge clk);
            #1;
            chk("mem_rd_en", bus.mem_rd_en, exp_rd());
            chk("mem_addr", bus.mem_addr, exp_addr());
            chk("recv_data", bus.flt_recv_data, m_rec);
            chk("pixel", bus.flt_pixel, m_pix);
            chk("out_valid", bus.out_valid, m_ov);
            chk("out_data", bus.out_data, m_od);
            chk("out_col", bus.out_col, m_col);
            chk("out_row", bus.out_row, m_row);
            chk("grad_cnt", grad_cnt, m_acc);
            chk("busy", busy, m_act);
            chk("done", done, m_done);
            chk("err_timeout", err_timeout, m_err);
`ifdef THRESHOLD_EN
            chk("out_edge", out_edge, m_edge);
            chk("edge_cnt", edge_cnt, m_ecnt);
            if (bus.out_valid) edges.push_back(out_edge);
`endif
            if (bus.flt_recv_data) begin
                chk("strobe_in_frame", strobes < P, 1);
                if (strobes < P) chk("pixel_order", bus.flt_pixel, mem_img[strobes]);
                strobes++;
            end
            if (bus.out_valid) coords.push_back(int'(bus.out_col) * 16 + int'(bus.out_row));
            if (done) begin
                done_total++;
                done_cyc = cyc;
            end
        end
    end

    int gen_left = 0, hold_left = 0;
    bit hold_en = 0, h10 = 0, h30 = 0;
    logic [GW-1:0] grad_q[$];

    task automatic drive(int pv, int pp, bit st);
        @(negedge clk);
        start = st;
        if (hold_left > 0) begin
            pause = 1;
            hold_left--;
        end else if (hold_en && busy && ((bus.mem_addr == 10 && !h10) || (bus.mem_addr == 30 && !h30))) begin
            if (bus.mem_addr == 10) h10 = 1; else h30 = 1;
            pause = 1;
            hold_left = 4;
        end else pause = $urandom_range(0, 99) < pp;
        bus.flt_gradient_valid = gen_left > 0 && $urandom_range(0, 99) < pv;
        if (bus.flt_gradient_valid) begin
            gen_left--;
            bus.flt_gradient = grad_q.size() > 0 ? grad_q.pop_front() : GW'($urandom_range(0, (1 << GW) - 1));
        end
    endtask

    task automatic run_frame(int nval, int pv, int pp, int restart_at, int rst_at);
        int d0;
        bit got;
        d0 = done_total;
        got = 0;
        h10 = 0;
        h30 = 0;
        for (int i = 0; i < P; i++) mem_img[i] = DW'($urandom);
        gen_left = 0;
        drive(pv, pp, 1);
        gen_left = nval;
        for (int c = 0; c < 4000 && !got; c++) begin
            drive(pv, pp, c == restart_at);
            if (c == 0) chk("err_clear_on_start", err_timeout, 0);
            if (rst_at >= 0 && busy && bus.mem_addr == AW'(rst_at)) begin
                #3 rst = 0;
                #1;
                chk("arst_mem_addr", bus.mem_addr, 0);
                chk("arst_rd_en", bus.mem_rd_en, 0);
                chk("arst_busy", busy, 0);
                chk("arst_grad_cnt", grad_cnt, 0);
                chk("arst_recv", bus.flt_recv_data, 0);
                chk("arst_pixel", bus.flt_pixel, 0);
                chk("arst_out_valid", bus.out_valid, 0);
                chk("arst_out_col", bus.out_col, 0);
                chk("arst_err", err_timeout, 0);
                repeat (3) @(negedge clk);
                rst = 1;
                chk("no_done_on_reset", done_total, d0);
                gen_left = 0;
                return;
            end
            got = done_total != d0;
        end
        chk("frame_done_seen", got, 1);
        gen_left = 2;
        repeat (6) drive(50, 0, 0);
        gen_left = 0;
    endtask

    initial begin
        int d0;
        bus.flt_gradient_valid = 0;
        bus.flt_gradient = '0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_mem_addr", bus.mem_addr, 0);
        chk("rst_grad_cnt", grad_cnt, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        @(negedge clk);
        rst = 1;

        d0 = done_total;
        run_frame(N + 3, 60, 0, -1, -1);
        chk("f1_grad_cnt", grad_cnt, N);
        chk("f1_err", err_timeout, 0);
        chk("f1_one_done", done_total - d0, 1);
        chk("f1_strobes", strobes, P);
        chk("f1_n_results", coords.size(), N);
        chk("f1_coord_first", coords[0], 1*16 + 1);
        chk("f1_coord_wrap", coords[6], 1*16 + 2);
        chk("f1_coord_last", coords[N-1], (W-2)*16 + (H-2));

        hold_en = 1;
        run_frame(N + 3, 40, 10, 5, -1);
        hold_en = 0;
        chk("f2_grad_cnt", grad_cnt, N);
        chk("f2_strobes", strobes, P);

        run_frame(3, 100, 0, -1, -1);
        chk("to_grad_cnt", grad_cnt, 3);
        chk("to_err", err_timeout, 1);
        chk("to_drain_len", done_cyc - last_rd_cyc, DM + 1);

        run_frame(N + 3, 70, 5, -1, -1);
        chk("after_to_err_clear", err_timeout, 0);

        repeat (5) run_frame(N + 3, int'($urandom_range(40, 95)), int'($urandom_range(0, 30)), -1, -1);

        run_frame(N + 3, 50, 10, -1, 20);
        run_frame(N + 3, 80, 0, -1, -1);
        chk("post_rst_grad_cnt", grad_cnt, N);

`ifdef THRESHOLD_EN
        threshold = 11'h080;
        grad_q = '{11'h07F, 11'h080, 11'h3FF, 11'h000};
        run_frame(4, 100, 0, -1, -1);
        chk("thr_n", edges.size(), 4);
        chk("thr_e0", edges[0], 0);
        chk("thr_e1", edges[1], 1);
        chk("thr_e2", edges[2], 1);
        chk("thr_e3", edges[3], 0);
        chk("thr_cnt", edge_cnt, 2);
`endif

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, tests %0d failed %0d", n_tests, n_fail);
        $fatal(1);
    end
endmodule
